// File: rtl/rosc_freq_meas_if.sv
// Control/result bundle between a measurement requester and rosc_freq_meas,
// including the ring-select/enable lines that go on to the rosc stress block.
interface rosc_freq_meas_if #(
   parameter int CNT_W = 16,
   parameter int WIN_W = 16
);
   logic             START_MEAS;
   logic [1:0]       ROSC_SEL;
   logic [WIN_W-1:0] WINDOW;
   logic             ROSC_OUT;

   logic             EN_ROSC;
   logic             MEAS_STRESS;
   logic             SEL_INV;
   logic             SEL_NAND;
   logic             SEL_NOR;
   logic             BUSY;
   logic             DONE;
   logic             ERR;
   logic [CNT_W-1:0] COUNT;
   logic             OVF;

   modport master (
      output START_MEAS, ROSC_SEL, WINDOW, ROSC_OUT,
      input  EN_ROSC, MEAS_STRESS, SEL_INV, SEL_NAND, SEL_NOR,
             BUSY, DONE, ERR, COUNT, OVF
   );

   modport slave (
      input  START_MEAS, ROSC_SEL, WINDOW, ROSC_OUT,
      output EN_ROSC, MEAS_STRESS, SEL_INV, SEL_NAND, SEL_NOR,
             BUSY, DONE, ERR, COUNT, OVF
   );
endinterface

// File: rtl/rosc_freq_meas.sv
// Measurement sequencer for the three-ring-oscillator stress block: settles the
// selected ring, counts its synchronized rising edges over a CLK window, then returns it to stress.
module rosc_freq_meas #(
   parameter int CNT_W      = 16,
   parameter int WIN_W      = 16,
   parameter int SETTLE_CYC = 8
) (
   input logic           CLK,
   input logic           RESETn,
   rosc_freq_meas_if.slave bus
);
   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int CYC_W = (WIN_W > SET_W) ? WIN_W : SET_W;
   localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_t;

   state_t           state;
   logic             sync_a, sync_b, prev, rise;
   logic [WIN_W-1:0] win_q;
   logic [CYC_W-1:0] cyc_cnt;
   logic [2:0]       sel_oh;          // {NOR, NAND, INV}
   logic             en_q, meas_q, busy_q, done_q, err_q, ovf_q;
   logic [CNT_W-1:0] count_q;
   logic             to_done;

   // NOTE: the default arm keeps the decode total, so nothing is left to hold its old value (no latch).
   function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
      case (sel)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // prev tracks the synchronized level in every state, so the first COUNT
   // cycle cannot see a stale low and report a phantom edge.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         prev   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let this chain shift one stage per clock regardless of statement order.
         sync_a <= bus.ROSC_OUT;
         sync_b <= sync_a;
         prev   <= sync_b;
      end
   end

   assign rise = sync_b & ~prev;

   assign to_done = ((state == S_SETTLE) && (cyc_cnt == '0) && (win_q == '0)) ||
                    ((state == S_COUNT)  && (cyc_cnt == '0));

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state   <= S_IDLE;
         win_q   <= '0;
         cyc_cnt <= '0;
         sel_oh  <= '0;
         en_q    <= 1'b0;
         meas_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         count_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (bus.START_MEAS) begin
                  if (bus.ROSC_SEL != 2'd3) begin
                     state   <= S_SETTLE;
                     win_q   <= bus.WINDOW;
                     cyc_cnt <= SETTLE_LAST;
                     count_q <= '0;
                     ovf_q   <= 1'b0;
                     sel_oh  <= sel_onehot(bus.ROSC_SEL);
                     en_q    <= 1'b1;
                     meas_q  <= 1'b1;
                     busy_q  <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end

            S_SETTLE: begin
               if (cyc_cnt == '0) begin
                  if (win_q != '0) begin
                     state   <= S_COUNT;
                     cyc_cnt <= CYC_W'(win_q) - CYC_W'(1);
                  end
               end else begin
                  cyc_cnt <= cyc_cnt - CYC_W'(1);
               end
            end

            S_COUNT: begin
               // Saturate rather than wrap; OVF records that an edge was lost.
               if (rise) begin
                  if (count_q == CNT_MAX) ovf_q   <= 1'b1;
                  else                    count_q <= count_q + CNT_W'(1);
               end
               if (cyc_cnt != '0) cyc_cnt <= cyc_cnt - CYC_W'(1);
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase

         if (to_done) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            en_q   <= 1'b0;
            meas_q <= 1'b0;
            sel_oh <= '0;
         end
      end
   end

   assign bus.EN_ROSC     = en_q;
   assign bus.MEAS_STRESS = meas_q;
   assign bus.SEL_INV     = sel_oh[0];
   assign bus.SEL_NAND    = sel_oh[1];
   assign bus.SEL_NOR     = sel_oh[2];
   assign bus.BUSY        = busy_q;
   assign bus.DONE        = done_q;
   assign bus.ERR         = err_q;
   assign bus.COUNT       = count_q;
   assign bus.OVF         = ovf_q;
endmodule

// File: doc/rosc_freq_meas.md
Name: rosc_freq_meas

Overview:
- Measurement sequencer and edge counter that sits directly downstream of the three-ring-oscillator stress block.
- Drives that block's control inputs: EN_ROSC, MEAS_STRESS and the one-hot SEL_INV/SEL_NAND/SEL_NOR.
- Counts rising edges of the block's OUT over a programmable CLK window. The result is the degradation-tracking frequency reading.
- Between measurements it holds the oscillators in stress mode.

Parameters:
- CNT_W, 16, width of edge count result
- WIN_W, 16, width of measurement window length (CLK cycles)
- SETTLE_CYC, 8, CLK cycles the oscillator runs before counting starts (edges ignored)

Ports:
- CLK  input  1  system clock, rising edge
- RESETn  input  1  asynchronous active-low reset
- START_MEAS  input  1  one-cycle request to start a measurement; honoured only in IDLE
- ROSC_SEL  input  2  0=INV, 1=NAND, 2=NOR, 3=invalid
- WINDOW  input  WIN_W  count window length in CLK cycles, sampled with START_MEAS
- ROSC_OUT  input  1  OUT of the rosc stress block, asynchronous to CLK
- EN_ROSC  output  1  oscillator enable to the rosc block
- MEAS_STRESS  output  1  1=measure (VDD to ring), 0=stress
- SEL_INV  output  1  ring select, one-hot with the two below
- SEL_NAND  output  1  ring select
- SEL_NOR  output  1  ring select
- BUSY  output  1  high from SETTLE through COUNT
- DONE  output  1  one-cycle pulse when COUNT is valid
- ERR  output  1  one-cycle pulse on START_MEAS with ROSC_SEL=3
- COUNT  output  CNT_W  edge count of last measurement, held until next accepted start
- OVF  output  1  count saturated during last measurement, held with COUNT

Behaviour:
- Reset (async, RESETn=0):
  - state=IDLE; all outputs 0; COUNT=0.
  - Synchronizer flops, edge-detect flop and internal counters cleared.
  - Reset mid-measurement aborts immediately; no DONE is produced.
- ROSC_OUT path:
  - Passes through a 2-flop synchronizer, then a previous-value flop.
  - edge = sync & ~prev.
  - prev updates every cycle in all states, so no spurious edge at window start.
  - Input high/low phases must each be ≥2 CLK periods; faster oscillators are pre-divided upstream.
- FSM states: IDLE, SETTLE, COUNT, DONE.
- IDLE:
  - EN_ROSC=0, MEAS_STRESS=0, SEL_*=0.
  - START_MEAS=1 and ROSC_SEL<3: latch ROSC_SEL and WINDOW; clear COUNT and OVF; go to SETTLE.
  - START_MEAS=1 and ROSC_SEL=3: pulse ERR next cycle; stay IDLE; COUNT unchanged.
- SETTLE:
  - EN_ROSC=1, MEAS_STRESS=1, latched SEL_* one-hot, BUSY=1.
  - Lasts exactly SETTLE_CYC cycles; edges ignored.
  - Then COUNT if latched WINDOW≠0, else DONE.
- COUNT:
  - Same outputs as SETTLE.
  - Lasts exactly latched WINDOW cycles.
  - Each cycle with edge=1: COUNT increments.
  - At COUNT = 2^CNT_W-1 the value holds and OVF is set (sticky).
  - Go to DONE after the last window cycle; an edge detected in that last cycle is counted.
- DONE:
  - One cycle: DONE=1, BUSY=0, EN_ROSC=0, MEAS_STRESS=0, SEL_*=0.
  - Return to IDLE.
- Latency: START_MEAS sampled at edge k → BUSY high from k+1 → DONE high at k+1+SETTLE_CYC+WINDOW.
- START_MEAS while not IDLE is ignored (including during DONE).
- All outputs are registered.
- SEL_* are never multi-hot, and are 0 whenever EN_ROSC=0.

Test Plan:
- Reset mid-COUNT (RESETn low 1 cycle while BUSY=1) → all outputs 0 immediately; no DONE; next START_MEAS works normally.
- ROSC_SEL=0, WINDOW=80, ROSC_OUT square wave period 8 CLK, first rise aligned after SETTLE → SEL_INV=1 for 88 cycles, DONE at start+89, COUNT=10, OVF=0.
- ROSC_SEL=2, WINDOW=0 → BUSY for exactly 8 cycles, DONE pulse, COUNT=0; SEL_NOR was the only select asserted.
- CNT_W=4, WINDOW=200, ROSC period 4 CLK → COUNT=15, OVF=1, both held until next accepted start.
- ROSC_SEL=3 with START_MEAS → ERR one cycle, BUSY stays 0, previous COUNT preserved.
- START_MEAS pulsed during SETTLE and during DONE → ignored; exactly one DONE per accepted start.
